// File: rtl/prediction_stat_tracker.sv
// rtl/prediction_stat_tracker.sv - per-predictor accuracy counters and trend states scored from an in-order FIFO of predictions
module prediction_stat_tracker #(
    parameter int STAT_COUNTER_WIDTH = 5,
    parameter int FIFO_DEPTH         = 4,
    parameter int DECAY_PERIOD       = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push_valid,
    output logic                          push_ready,
    input  logic                          SP_prediction_in,
    input  logic                          LHP_prediction_in,
    input  logic                          GHP_prediction_in,
    input  logic                          resolve_valid,
    output logic                          resolve_ready,
    input  logic                          actual_taken,
    input  logic                          flush,
    output logic [STAT_COUNTER_WIDTH-1:0] SP_stat_count,
    output logic [STAT_COUNTER_WIDTH-1:0] LHP_stat_count,
    output logic [STAT_COUNTER_WIDTH-1:0] GHP_stat_count,
    output logic [3:0]                    SP_trend_decode,
    output logic [3:0]                    LHP_trend_decode,
    output logic [3:0]                    GHP_trend_decode
);
    localparam int W  = STAT_COUNTER_WIDTH;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int DW = $clog2(DECAY_PERIOD + 1);

    localparam logic [PW:0]   FULL_OCC   = (PW + 1)'(FIFO_DEPTH);
    localparam logic [DW-1:0] DECAY_LAST = DW'(DECAY_PERIOD - 1);
    localparam logic [W-1:0]  STAT_MAX   = '1;
    localparam logic [W-1:0]  STAT_INIT  = {1'b1, {(W - 1){1'b0}}};

    typedef enum logic [1:0] {
        STRONG_WRONG = 2'd0,
        WEAK_WRONG   = 2'd1,
        WEAK_RIGHT   = 2'd2,
        STRONG_RIGHT = 2'd3
    } trend_t;

    // Entry bit order {SP, LHP, GHP}; predictor index 2=SP, 1=LHP, 0=GHP throughout.
    logic [2:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   occupancy;
    logic [DW-1:0] decay_q;
    logic [DW-1:0] decay_d;
    logic [W-1:0]  stat_q [3];
    logic [W-1:0]  stat_d [3];
    trend_t        trend_q [3];
    trend_t        trend_d [3];

    logic       push_fire;
    logic       pop_fire;
    logic       decay_hit;
    logic [2:0] head;

    assign push_ready    = (occupancy != FULL_OCC);
    assign resolve_ready = (occupancy != '0);
    assign push_fire     = push_valid && push_ready;
    assign pop_fire      = resolve_valid && resolve_ready;
    assign head          = fifo_mem[rd_ptr];

    function automatic trend_t trend_step(trend_t t, logic up);
        case (t)
            STRONG_WRONG: return up ? WEAK_WRONG   : STRONG_WRONG;
            WEAK_WRONG:   return up ? WEAK_RIGHT   : STRONG_WRONG;
            WEAK_RIGHT:   return up ? STRONG_RIGHT : WEAK_WRONG;
            default:      return up ? STRONG_RIGHT : WEAK_RIGHT;
        endcase
    endfunction

    // Decay halves after the resolve's own update has been applied.
    function automatic logic [W-1:0] stat_step(logic [W-1:0] c, logic up, logic halve);
        logic [W-1:0] n;
        if (up) begin
            n = (c == STAT_MAX) ? c : c + W'(1);
        end else begin
            n = (c < W'(2)) ? '0 : c - W'(2);
        end
        return halve ? (n >> 1) : n;
    endfunction

    function automatic logic [3:0] trend_decode(trend_t t);
        return 4'b0001 << t;
    endfunction

    always_comb begin
        decay_d   = decay_q;
        decay_hit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            stat_d[i]  = stat_q[i];
            trend_d[i] = trend_q[i];
        end
        if (pop_fire) begin
            decay_hit = (decay_q == DECAY_LAST);
            decay_d   = decay_hit ? '0 : decay_q + DW'(1);
            for (int i = 0; i < 3; i++) begin
                stat_d[i]  = stat_step(stat_q[i], head[i] == actual_taken, decay_hit);
                trend_d[i] = trend_step(trend_q[i], head[i] == actual_taken);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
            decay_q   <= '0;
            for (int i = 0; i < 3; i++) begin
                stat_q[i]  <= STAT_INIT;
                trend_q[i] <= WEAK_RIGHT;
            end
        end else begin
            decay_q <= decay_d;
            for (int i = 0; i < 3; i++) begin
                stat_q[i]  <= stat_d[i];
                trend_q[i] <= trend_d[i];
            end
            // A flush wins over the FIFO bookkeeping but not over scoring.
            if (flush) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                occupancy <= '0;
            end else begin
                if (push_fire) begin
                    fifo_mem[wr_ptr] <= {SP_prediction_in, LHP_prediction_in, GHP_prediction_in};
                    wr_ptr           <= wr_ptr + PW'(1);
                end
                if (pop_fire) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                case ({push_fire, pop_fire})
                    2'b10:   occupancy <= occupancy + (PW + 1)'(1);
                    2'b01:   occupancy <= occupancy - (PW + 1)'(1);
                    default: occupancy <= occupancy;
                endcase
            end
        end
    end

    assign SP_stat_count    = stat_q[2];
    assign LHP_stat_count   = stat_q[1];
    assign GHP_stat_count   = stat_q[0];
    assign SP_trend_decode  = trend_decode(trend_q[2]);
    assign LHP_trend_decode = trend_decode(trend_q[1]);
    assign GHP_trend_decode = trend_decode(trend_q[0]);
endmodule

// File: tb/tb_prediction_stat_tracker.sv
// tb/tb_prediction_stat_tracker.sv - scoreboard bench for prediction_stat_tracker (default and short-decay instances)
module tb_prediction_stat_tracker;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       push_valid = 0, sp_in = 0, lhp_in = 0, ghp_in = 0;
    logic       resolve_valid = 0, actual = 0, flush = 0;
    logic       push_ready, resolve_ready;
    logic [4:0] sp_cnt, lhp_cnt, ghp_cnt;
    logic [3:0] sp_dec, lhp_dec, ghp_dec;

    logic       d_push_valid = 0, d_sp_in = 0, d_resolve_valid = 0, d_actual = 0;
    logic       d_push_ready, d_resolve_ready;
    logic [4:0] d_sp_cnt, d_lhp_cnt, d_ghp_cnt;
    logic [3:0] d_sp_dec, d_lhp_dec, d_ghp_dec;

    prediction_stat_tracker #(.STAT_COUNTER_WIDTH(5), .FIFO_DEPTH(4), .DECAY_PERIOD(64)) dut (
        .clk(clk), .rst(rst),
        .push_valid(push_valid), .push_ready(push_ready),
        .SP_prediction_in(sp_in), .LHP_prediction_in(lhp_in), .GHP_prediction_in(ghp_in),
        .resolve_valid(resolve_valid), .resolve_ready(resolve_ready),
        .actual_taken(actual), .flush(flush),
        .SP_stat_count(sp_cnt), .LHP_stat_count(lhp_cnt), .GHP_stat_count(ghp_cnt),
        .SP_trend_decode(sp_dec), .LHP_trend_decode(lhp_dec), .GHP_trend_decode(ghp_dec)
    );

    prediction_stat_tracker #(.STAT_COUNTER_WIDTH(5), .FIFO_DEPTH(4), .DECAY_PERIOD(4)) dut_decay (
        .clk(clk), .rst(rst),
        .push_valid(d_push_valid), .push_ready(d_push_ready),
        .SP_prediction_in(d_sp_in), .LHP_prediction_in(1'b1), .GHP_prediction_in(1'b1),
        .resolve_valid(d_resolve_valid), .resolve_ready(d_resolve_ready),
        .actual_taken(d_actual), .flush(1'b0),
        .SP_stat_count(d_sp_cnt), .LHP_stat_count(d_lhp_cnt), .GHP_stat_count(d_ghp_cnt),
        .SP_trend_decode(d_sp_dec), .LHP_trend_decode(d_lhp_dec), .GHP_trend_decode(d_ghp_dec)
    );

    typedef struct {
        string name;
        int    sel;
        int    value;
    } check_t;

    check_t scoreboard[$];
    int checks = 0;
    int errors = 0;

    function automatic int observe(int sel);
        case (sel)
            0: return int'(sp_cnt);
            1: return int'(lhp_cnt);
            2: return int'(ghp_cnt);
            3: return int'(sp_dec);
            4: return int'(lhp_dec);
            5: return int'(ghp_dec);
            6: return int'(push_ready);
            7: return int'(resolve_ready);
            8: return int'(d_sp_cnt);
            default: return int'(d_resolve_ready);
        endcase
    endfunction

    // Registered outputs are sampled on the falling edge, after the update edge.
    always @(negedge clk) begin
        while (scoreboard.size() > 0) begin
            check_t c;
            int act;
            c = scoreboard.pop_front();
            act = observe(c.sel);
            checks++;
            if (act != c.value) begin
                errors++;
                $display("FAIL %s: got %0d, expected %0d", c.name, act, c.value);
            end
        end
    end

    task automatic expect_val(input string name, input int sel, input int value);
        check_t c;
        c.name = name;
        c.sel = sel;
        c.value = value;
        scoreboard.push_back(c);
    endtask

    task automatic cyc(input logic pv, input logic sp, input logic lhp, input logic ghp,
                       input logic rv, input logic act, input logic fl);
        @(negedge clk);
        #1;
        push_valid = pv; sp_in = sp; lhp_in = lhp; ghp_in = ghp;
        resolve_valid = rv; actual = act; flush = fl;
        @(posedge clk);
        #1;
        push_valid = 0; resolve_valid = 0; flush = 0;
    endtask

    task automatic dcyc(input logic pv, input logic sp, input logic rv, input logic act);
        @(negedge clk);
        #1;
        d_push_valid = pv; d_sp_in = sp; d_resolve_valid = rv; d_actual = act;
        @(posedge clk);
        #1;
        d_push_valid = 0; d_resolve_valid = 0;
    endtask

    int dexp[8] = '{17, 15, 16, 7, 8, 6, 7, 2};

    initial begin
        repeat (3) @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1;
        expect_val("rst_sp_cnt", 0, 16);
        expect_val("rst_ghp_cnt", 2, 16);
        expect_val("rst_sp_dec", 3, 4);
        expect_val("rst_lhp_dec", 4, 4);
        expect_val("rst_push_ready", 6, 1);
        expect_val("rst_resolve_ready", 7, 0);
        expect_val("rst_decay_sp_cnt", 8, 16);

        // Basic scoring sequence
        cyc(1, 1, 0, 1, 0, 0, 0);
        cyc(1, 0, 0, 1, 0, 0, 0);
        cyc(1, 1, 1, 1, 0, 0, 0);
        expect_val("t1_resolve_ready", 7, 1);
        cyc(0, 0, 0, 0, 1, 1, 0);
        expect_val("t1_sp_cnt_1", 0, 17);
        expect_val("t1_sp_dec_1", 3, 8);
        cyc(0, 0, 0, 0, 1, 1, 0);
        expect_val("t1_sp_cnt_2", 0, 15);
        expect_val("t1_sp_dec_2", 3, 4);
        cyc(0, 0, 0, 0, 1, 1, 0);
        expect_val("t1_sp_cnt_3", 0, 16);
        expect_val("t1_sp_dec_3", 3, 8);
        expect_val("t1_lhp_cnt", 1, 13);
        expect_val("t1_lhp_dec", 4, 2);
        expect_val("t1_ghp_cnt", 2, 19);
        expect_val("t1_ghp_dec", 5, 8);
        expect_val("t1_resolve_ready_empty", 7, 0);

        // Full FIFO, dropped push, simultaneous push+pop, ordering
        cyc(1, 1, 1, 1, 0, 0, 0);
        cyc(1, 0, 1, 1, 0, 0, 0);
        cyc(1, 0, 1, 1, 0, 0, 0);
        cyc(1, 1, 1, 1, 0, 0, 0);
        expect_val("t2_full_push_ready", 6, 0);
        expect_val("t2_full_resolve_ready", 7, 1);
        cyc(1, 0, 0, 0, 0, 0, 0);
        expect_val("t2_drop_push_ready", 6, 0);
        cyc(0, 0, 0, 0, 1, 1, 0);
        expect_val("t2_pop_a_sp", 0, 17);
        expect_val("t2_pop_a_push_ready", 6, 1);
        cyc(1, 0, 1, 1, 1, 1, 0);
        expect_val("t2_pushpop_sp", 0, 15);
        expect_val("t2_pushpop_push_ready", 6, 1);
        expect_val("t2_pushpop_resolve_ready", 7, 1);
        cyc(0, 0, 0, 0, 1, 1, 0);
        expect_val("t2_pop_c_sp", 0, 13);
        cyc(0, 0, 0, 0, 1, 1, 0);
        expect_val("t2_pop_d_sp", 0, 14);
        cyc(0, 0, 0, 0, 1, 1, 0);
        expect_val("t2_pop_f_sp", 0, 12);
        expect_val("t2_pop_f_sp_dec", 3, 2);
        expect_val("t2_empty_resolve_ready", 7, 0);
        expect_val("t2_lhp_cnt", 1, 18);
        expect_val("t2_lhp_dec", 4, 8);
        expect_val("t2_ghp_cnt", 2, 24);

        // Resolve while empty changes nothing
        cyc(0, 0, 0, 0, 1, 0, 0);
        expect_val("t3_sp_cnt", 0, 12);
        expect_val("t3_sp_dec", 3, 2);
        expect_val("t3_lhp_cnt", 1, 18);
        expect_val("t3_resolve_ready", 7, 0);

        // Saturation up then down
        for (int i = 0; i < 20; i++) begin
            cyc(1, 1, 1, 1, 0, 0, 0);
            cyc(0, 0, 0, 0, 1, 1, 0);
        end
        expect_val("t4_sat_hi_sp", 0, 31);
        expect_val("t4_sat_hi_sp_dec", 3, 8);
        expect_val("t4_sat_hi_lhp", 1, 31);
        expect_val("t4_sat_hi_ghp", 2, 31);
        cyc(1, 1, 1, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0);
        expect_val("t4_first_wrong_sp", 0, 29);
        expect_val("t4_first_wrong_dec", 3, 4);
        for (int i = 0; i < 19; i++) begin
            cyc(1, 1, 1, 1, 0, 0, 0);
            cyc(0, 0, 0, 0, 1, 0, 0);
        end
        expect_val("t4_sat_lo_sp", 0, 0);
        expect_val("t4_sat_lo_sp_dec", 3, 1);
        expect_val("t4_sat_lo_lhp", 1, 0);
        expect_val("t4_sat_lo_ghp_dec", 5, 1);

        // Flush with two pending, simultaneous resolve and push
        cyc(1, 1, 0, 1, 0, 0, 0);
        cyc(1, 1, 1, 1, 0, 0, 0);
        cyc(1, 1, 1, 1, 1, 1, 1);
        expect_val("t5_flush_sp", 0, 1);
        expect_val("t5_flush_sp_dec", 3, 2);
        expect_val("t5_flush_lhp", 1, 0);
        expect_val("t5_flush_ghp_dec", 5, 2);
        expect_val("t5_flush_resolve_ready", 7, 0);
        expect_val("t5_flush_push_ready", 6, 1);
        cyc(0, 0, 0, 0, 1, 1, 0);
        expect_val("t5_after_flush_empty_sp", 0, 1);
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 1, 0);
        expect_val("t5_next_entry_sp", 0, 0);
        expect_val("t5_next_entry_sp_dec", 3, 1);
        expect_val("t5_final_resolve_ready", 7, 0);

        // Short-period decay instance, with an empty resolve after the 5th
        for (int k = 0; k < 8; k++) begin
            dcyc(1, 1, 0, 0);
            dcyc(0, 0, 1, (k % 2 == 0) ? 1'b1 : 1'b0);
            expect_val($sformatf("t6_decay_sp_%0d", k + 1), 8, dexp[k]);
            if (k == 4) begin
                dcyc(0, 0, 1, 1);
                expect_val("t6_empty_resolve_sp", 8, 8);
                expect_val("t6_empty_resolve_ready", 9, 0);
            end
        end

        repeat (3) @(negedge clk);
        #1;
        if (scoreboard.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", scoreboard.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
